// File: rtl/axi_lite_slave_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
  typedef enum logic { RD_IDLE, RD_DATA } rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int k = 0; k < 4; k++)
      res[8*k +: 8] = strb[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register file slave.
interface axi_lite_slave_regfile_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave with NUM_REGS 32-bit control registers; independent write and read FSMs,
// one outstanding transaction per direction, all bus outputs registered.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi_lite_slave_regfile_if.slave        s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e                          wr_state_q, wr_state_d;
  logic                               aw_held_q, aw_held_d;
  logic [IDX_W-1:0]                   aw_idx_q, aw_idx_d;
  logic                               w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]              w_data_q, w_data_d;
  logic [STRB_W-1:0]                  w_strb_q, w_strb_d;
  logic                               bvalid_q, bvalid_d;
  logic [1:0]                         bresp_q, bresp_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                pulse_q, pulse_d;
  logic                               ready_en_q, ready_en_d;

  rd_state_e                          rd_state_q, rd_state_d;
  logic                               rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]              rdata_q, rdata_d;
  logic [1:0]                         rresp_q, rresp_d;

  logic                  awready, wready, arready, aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]      wr_idx, ar_idx;
  logic [DATA_WIDTH-1:0] w_data_eff;
  logic [STRB_W-1:0]     w_strb_eff;
  logic                  unused_sigs;

  // ready_en_q keeps every READY low while reset is held and for the release cycle
  assign awready = ready_en_q && (wr_state_q == WR_IDLE) && !aw_held_q;
  assign wready  = ready_en_q && (wr_state_q == WR_IDLE) && !w_held_q;
  assign arready = ready_en_q && (rd_state_q == RD_IDLE);
  assign aw_hs   = s_axi.S_AXI_AWVALID && awready;
  assign w_hs    = s_axi.S_AXI_WVALID && wready;
  assign ar_hs   = s_axi.S_AXI_ARVALID && arready;

  assign wr_idx     = aw_held_q ? aw_idx_q : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign w_data_eff = w_held_q ? w_data_q : s_axi.S_AXI_WDATA;
  assign w_strb_eff = w_held_q ? w_strb_q : s_axi.S_AXI_WSTRB;
  assign ar_idx     = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];

  assign unused_sigs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    pulse_d    = '0;
    case (wr_state_q)
      WR_IDLE: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_SLVERR;
          wr_state_d = WR_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
              regs_d[i]  = strb_merge(regs_q[i], w_data_eff, w_strb_eff);
              pulse_d[i] = 1'b1;
              bresp_d    = RESP_OKAY;
            end
          end
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
          end
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-cycle write commit is not yet visible
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ready_en_d = 1'b1;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      regs_q     <= '0;
      pulse_q    <= '0;
      ready_en_q <= 1'b0;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      ready_en_q <= ready_en_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_out             = regs_q;
  assign reg_wr_pulse        = pulse_q;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench: two DUTs (4 and 3 registers) driven in lockstep; sel picks which is observed.
module tb_axi_lite_slave_regfile;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        sel = 0;
  int          checks = 0, passes = 0;

  axi_lite_slave_regfile_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifa ();
  axi_lite_slave_regfile_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifb ();
  logic [127:0] regout_a;
  logic [95:0]  regout_b;
  logic [3:0]   pulse_a;
  logic [2:0]   pulse_b;

  assign ifa.S_AXI_AWADDR = awaddr;  assign ifb.S_AXI_AWADDR = awaddr;
  assign ifa.S_AXI_AWPROT = 3'b000;  assign ifb.S_AXI_AWPROT = 3'b000;
  assign ifa.S_AXI_AWVALID = awvalid; assign ifb.S_AXI_AWVALID = awvalid;
  assign ifa.S_AXI_WDATA = wdata;    assign ifb.S_AXI_WDATA = wdata;
  assign ifa.S_AXI_WSTRB = wstrb;    assign ifb.S_AXI_WSTRB = wstrb;
  assign ifa.S_AXI_WVALID = wvalid;  assign ifb.S_AXI_WVALID = wvalid;
  assign ifa.S_AXI_BREADY = bready;  assign ifb.S_AXI_BREADY = bready;
  assign ifa.S_AXI_ARADDR = araddr;  assign ifb.S_AXI_ARADDR = araddr;
  assign ifa.S_AXI_ARPROT = 3'b000;  assign ifb.S_AXI_ARPROT = 3'b000;
  assign ifa.S_AXI_ARVALID = arvalid; assign ifb.S_AXI_ARVALID = arvalid;
  assign ifa.S_AXI_RREADY = rready;  assign ifb.S_AXI_RREADY = rready;

  axi_lite_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(ifa), .reg_out(regout_a), .reg_wr_pulse(pulse_a));
  axi_lite_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(ifb), .reg_out(regout_b), .reg_wr_pulse(pulse_b));

  wire         awready_o = sel ? ifb.S_AXI_AWREADY : ifa.S_AXI_AWREADY;
  wire         wready_o  = sel ? ifb.S_AXI_WREADY  : ifa.S_AXI_WREADY;
  wire         arready_o = sel ? ifb.S_AXI_ARREADY : ifa.S_AXI_ARREADY;
  wire         bvalid_o  = sel ? ifb.S_AXI_BVALID  : ifa.S_AXI_BVALID;
  wire [1:0]   bresp_o   = sel ? ifb.S_AXI_BRESP   : ifa.S_AXI_BRESP;
  wire         rvalid_o  = sel ? ifb.S_AXI_RVALID  : ifa.S_AXI_RVALID;
  wire [31:0]  rdata_o   = sel ? ifb.S_AXI_RDATA   : ifa.S_AXI_RDATA;
  wire [1:0]   rresp_o   = sel ? ifb.S_AXI_RRESP   : ifa.S_AXI_RRESP;
  wire [127:0] regout_o  = sel ? {32'h0, regout_b} : regout_a;
  wire [3:0]   pulse_o   = sel ? {1'b0, pulse_b}   : pulse_a;

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse);
    int n;
    bit aw_fire, w_fire;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_fire = awvalid && awready_o;
      w_fire  = wvalid && wready_o;
      tick();
      if (aw_fire) awvalid = 0;
      if (w_fire) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid_o && n < 20) begin tick(); n++; end
    checks++; if (bvalid_o !== 1'b1) $display("FAIL write_bvalid addr %h: got %b want 1", addr, bvalid_o); else passes++;
    resp = bresp_o; pulse = pulse_o;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1; rready = 0;
    n = 0;
    while (!arready_o && n < 20) begin tick(); n++; end
    tick(); arvalid = 0;
    n = 0;
    while (!rvalid_o && n < 20) begin tick(); n++; end
    checks++; if (rvalid_o !== 1'b1) $display("FAIL read_rvalid addr %h: got %b want 1", addr, rvalid_o); else passes++;
    data = rdata_o; resp = rresp_o;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    ARESETN = 0; tick(); tick();
    checks++; if ({awready_o, wready_o, arready_o} !== 3'b000) $display("FAIL reset_ready: got %b want 000", {awready_o, wready_o, arready_o}); else passes++;
    checks++; if ({bvalid_o, rvalid_o, bresp_o, rresp_o} !== 6'b0) $display("FAIL reset_valid_resp: got %b want 000000", {bvalid_o, rvalid_o, bresp_o, rresp_o}); else passes++;
    checks++; if (rdata_o !== 32'h0 || regout_o !== 128'h0 || pulse_o !== 4'h0) $display("FAIL reset_data: rdata %h reg_out %h pulse %b want 0", rdata_o, regout_o, pulse_o); else passes++;
    ARESETN = 1; #1;
    checks++; if (awready_o !== 1'b0) $display("FAIL release_awready_early: got %b want 0", awready_o); else passes++;
    tick();
    checks++; if ({awready_o, wready_o, arready_o} !== 3'b111) $display("FAIL release_ready: got %b want 111", {awready_o, wready_o, arready_o}); else passes++;
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp, pulse);
      checks++; if (resp !== 2'b00) $display("FAIL basic_bresp %0d: got %b want 00", i, resp); else passes++;
      checks++; if (pulse !== 4'(1 << i)) $display("FAIL basic_pulse %0d: got %b want %b", i, pulse, 4'(1 << i)); else passes++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp);
      checks++; if (d !== 32'(i + 1) || resp !== 2'b00) $display("FAIL basic_read %0d: got %h/%b want %h/00", i, d, resp, 32'(i + 1)); else passes++;
    end
    checks++; if (regout_o !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL basic_reg_out: got %h want 4_3_2_1", regout_o); else passes++;
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] d;
    axi_write(4'h0, 32'h11223344, 4'hF, resp, pulse);
    axi_write(4'h0, 32'hAABBCCDD, 4'b0010, resp, pulse);
    axi_read(4'h0, d, resp);
    checks++; if (d !== 32'h1122CC44) $display("FAIL strobe_merge: got %h want 1122cc44", d); else passes++;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d;
    wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1; awaddr = 4'h4;
    tick(); wvalid = 0;
    checks++; if (wready_o !== 1'b0 || awready_o !== 1'b1) $display("FAIL w_held_ready: got w%b aw%b want w0 aw1", wready_o, awready_o); else passes++;
    tick(); tick();
    checks++; if (bvalid_o !== 1'b0) $display("FAIL w_only_bvalid: got %b want 0", bvalid_o); else passes++;
    awvalid = 1; tick(); awvalid = 0;
    checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || pulse_o !== 4'b0010) $display("FAIL aw_late_commit: bvalid %b bresp %b pulse %b want 1 00 0010", bvalid_o, bresp_o, pulse_o); else passes++;
    bready = 1; tick(); bready = 0;
    checks++; if (bvalid_o !== 1'b0 || pulse_o !== 4'b0000) $display("FAIL aw_late_bdone: bvalid %b pulse %b want 0 0000", bvalid_o, pulse_o); else passes++;
    axi_read(4'h4, d, resp);
    checks++; if (d !== 32'hCAFE0001) $display("FAIL aw_late_read: got %h want cafe0001", d); else passes++;
  endtask

  task automatic test_bready_stall();
    int n; bit got_r; logic [31:0] rd;
    awaddr = 4'h8; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    tick(); awvalid = 0; wvalid = 0;
    araddr = 4'hC; arvalid = 1; rready = 1; got_r = 0; rd = '0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || awready_o !== 1'b0 || wready_o !== 1'b0) $display("FAIL stall_cycle %0d: bvalid %b bresp %b awr %b wr %b want 1 00 0 0", c, bvalid_o, bresp_o, awready_o, wready_o); else passes++;
      if (rvalid_o && !got_r) begin got_r = 1; rd = rdata_o; end
      tick(); arvalid = 0; n++;
    end
    rready = 0;
    checks++; if (!got_r || rd !== 32'd4) $display("FAIL stall_concurrent_read: seen %b data %h want 1 00000004", got_r, rd); else passes++;
    bready = 1; tick(); bready = 0;
    checks++; if (bvalid_o !== 1'b0 || awready_o !== 1'b1) $display("FAIL stall_release: bvalid %b awready %b want 0 1", bvalid_o, awready_o); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] d;
    rready = 0; araddr = 4'h0; arvalid = 1; awaddr = 4'h8; awvalid = 1; wvalid = 0;
    tick(); arvalid = 0; awvalid = 0;
    checks++; if (rvalid_o !== 1'b1 || awready_o !== 1'b0 || wready_o !== 1'b1) $display("FAIL mid_setup: rvalid %b awr %b wr %b want 1 0 1", rvalid_o, awready_o, wready_o); else passes++;
    ARESETN = 0; #1;
    checks++; if ({rvalid_o, bvalid_o, awready_o, wready_o, arready_o} !== 5'b0 || rdata_o !== 32'h0 || regout_o !== 128'h0) $display("FAIL mid_reset_outputs: flags %b rdata %h reg_out %h want 0", {rvalid_o, bvalid_o, awready_o, wready_o, arready_o}, rdata_o, regout_o); else passes++;
    tick(); tick(); ARESETN = 1; tick();
    axi_write(4'h4, 32'h00000077, 4'hF, resp, pulse);
    checks++; if (pulse !== 4'b0010 || resp !== 2'b00) $display("FAIL mid_clean_write: pulse %b resp %b want 0010 00", pulse, resp); else passes++;
    axi_read(4'h8, d, resp);
    checks++; if (d !== 32'h0) $display("FAIL mid_stale_aw: reg2 got %h want 0", d); else passes++;
    axi_read(4'h4, d, resp);
    checks++; if (d !== 32'h77) $display("FAIL mid_new_write: reg1 got %h want 77", d); else passes++;
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] d;
    sel = 1;
    axi_write(4'h0, 32'hA, 4'hF, resp, pulse);
    axi_write(4'h4, 32'hB, 4'hF, resp, pulse);
    axi_write(4'h8, 32'hC, 4'hF, resp, pulse);
    axi_write(4'hC, 32'hDEAD, 4'hF, resp, pulse);
    checks++; if (resp !== 2'b10 || pulse !== 4'b0000) $display("FAIL slverr_write: resp %b pulse %b want 10 0000", resp, pulse); else passes++;
    axi_read(4'hC, d, resp);
    checks++; if (d !== 32'h0 || resp !== 2'b10) $display("FAIL slverr_read: got %h/%b want 0/10", d, resp); else passes++;
    axi_read(4'h8, d, resp);
    checks++; if (d !== 32'hC || resp !== 2'b00) $display("FAIL slverr_last_valid: got %h/%b want c/00", d, resp); else passes++;
    checks++; if (regout_o !== {32'h0, 32'hC, 32'hB, 32'hA}) $display("FAIL slverr_reg_out: got %h want 0_c_b_a", regout_o); else passes++;
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_bready_stall();
    test_reset_mid();
    test_slverr();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
